// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encoding, screen limits and default bird physics constants.
package flappy_pkg;
  typedef enum logic [1:0] {S_INITIAL, S_FLIGHT, S_STOP} state_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int DEF_TICK_DIV = 833333;
  localparam int DEF_BIRD_X = 160;
  localparam int DEF_Y_INIT = 240;
  localparam int DEF_HALF = 10;
  localparam int DEF_GRAVITY = 1;
  localparam int DEF_JUMP_VEL = -8;
  localparam int DEF_VMAX = 8;
  localparam int DEF_Y_MIN = 10;
  localparam int DEF_Y_MAX = 470;
endpackage

// File: rtl/bird_tick_gen.sv
// bird_tick_gen: divides board_clk into a one-cycle physics tick strobe every TICK_DIV cycles.
module bird_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic board_clk,
  input  logic Reset,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge board_clk or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
endmodule

// File: rtl/bird_motion.sv
// bird_motion: bird game FSM with tick-driven gravity/jump physics and a registered bounding box.
module bird_motion import flappy_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int BIRD_X = DEF_BIRD_X,
  parameter int Y_INIT = DEF_Y_INIT,
  parameter int HALF = DEF_HALF,
  parameter int GRAVITY = DEF_GRAVITY,
  parameter int JUMP_VEL = DEF_JUMP_VEL,
  parameter int VMAX = DEF_VMAX,
  parameter int Y_MIN = DEF_Y_MIN,
  parameter int Y_MAX = DEF_Y_MAX
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       ack,
  input  logic       jump,
  input  logic       stop,
  output logic [9:0] bird_x_l,
  output logic [9:0] bird_x_r,
  output logic [9:0] bird_y_t,
  output logic [9:0] bird_y_b,
  output logic [9:0] velocity,
  output logic       q_initial,
  output logic       q_flight,
  output logic       q_stop,
  output logic       tick
);
  if (Y_MIN < HALF || Y_MAX + HALF > SCREEN_H) begin : g_bad_limits
    $error("bird_motion: vertical limits let the box leave the screen");
  end
  localparam logic signed [10:0] G = 11'(GRAVITY);
  localparam logic signed [10:0] JV = 11'(JUMP_VEL);
  localparam logic signed [10:0] VM = 11'(VMAX);
  localparam logic signed [10:0] YLO = 11'(Y_MIN);
  localparam logic signed [10:0] YHI = 11'(Y_MAX);
  state_t state, state_n;
  logic [9:0] y, y_n, vel, vel_n;
  logic jp, jp_n;
  logic signed [10:0] vel_s, vel_g, vel_c, y_c;
  bird_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .board_clk(board_clk),
    .Reset(Reset),
    .tick(tick)
  );
  // 11-bit signed sums so an overshoot past either limit is seen before clamping
  always_comb begin
    vel_s = {vel[9], vel};
    vel_g = (vel_s + G > VM) ? VM : vel_s + G;
    vel_c = jp ? JV : vel_g;
    y_c = $signed({1'b0, y}) + vel_c;
    state_n = state;
    y_n = y;
    vel_n = vel;
    jp_n = 1'b0;
    unique case (state)
      S_INITIAL: begin
        y_n = 10'(Y_INIT);
        vel_n = '0;
        state_n = start ? S_FLIGHT : S_INITIAL;
      end
      S_FLIGHT: begin
        jp_n = jump | (jp & ~tick);
        if (stop) begin
          state_n = S_STOP;
          jp_n = 1'b0;
        end else if (tick) begin
          y_n = y_c <= YLO ? 10'(Y_MIN) : y_c >= YHI ? 10'(Y_MAX) : 10'(y_c);
          vel_n = (y_c <= YLO || y_c >= YHI) ? '0 : 10'(vel_c);
          if (y_c > YLO && y_c >= YHI) begin
            state_n = S_STOP;
            jp_n = 1'b0;
          end
        end
      end
      S_STOP: begin
        state_n = ack ? S_INITIAL : S_STOP;
        y_n = ack ? 10'(Y_INIT) : y;
        vel_n = ack ? '0 : vel;
      end
      default: state_n = S_INITIAL;
    endcase
  end
  always_ff @(posedge board_clk or posedge Reset)
    if (Reset) begin
      state <= S_INITIAL;
      y <= 10'(Y_INIT);
      vel <= '0;
      jp <= 1'b0;
      bird_y_t <= 10'(Y_INIT - HALF);
      bird_y_b <= 10'(Y_INIT + HALF);
    end else begin
      state <= state_n;
      y <= y_n;
      vel <= vel_n;
      jp <= jp_n;
      bird_y_t <= y_n - 10'(HALF);
      bird_y_b <= y_n + 10'(HALF);
    end
  assign bird_x_l = 10'(BIRD_X - HALF);
  assign bird_x_r = 10'(BIRD_X + HALF);
  assign velocity = vel;
  assign q_initial = state == S_INITIAL;
  assign q_flight = state == S_FLIGHT;
  assign q_stop = state == S_STOP;
endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: scoreboard bench; per-tick expectations are queued by stimulus and checked by a monitor.
module tb_bird_motion;
  logic board_clk = 0, Reset = 1, start = 0, ack = 0, jump = 0, stop = 0;
  logic [9:0] bird_x_l, bird_x_r, bird_y_t, bird_y_b, velocity;
  logic q_initial, q_flight, q_stop, tick;
  typedef struct {string name; int y; int v; logic [2:0] q;} exp_t;
  localparam logic [2:0] QI = 3'b100, QF = 3'b010, QS = 3'b001;
  exp_t sb[$];
  int pend = 0, total = 0, bad = 0;
  int my = 240, mv = 0;
  logic [2:0] mq = QI;
  always #5 board_clk = ~board_clk;
  bird_motion #(.TICK_DIV(4)) dut (
    .board_clk(board_clk), .Reset(Reset), .start(start), .ack(ack), .jump(jump), .stop(stop),
    .bird_x_l(bird_x_l), .bird_x_r(bird_x_r), .bird_y_t(bird_y_t), .bird_y_b(bird_y_b),
    .velocity(velocity), .q_initial(q_initial), .q_flight(q_flight), .q_stop(q_stop), .tick(tick)
  );
  function automatic logic [2:0] qv();
    return {q_initial, q_flight, q_stop};
  endfunction
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask
  always @(negedge board_clk)
    if (!Reset && tick && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      @(negedge board_clk);
      total++;
      if (bird_y_t != 10'(e.y - 10) || bird_y_b != 10'(e.y + 10) || $signed(velocity) != e.v || qv() != e.q) begin
        bad++;
        $display("FAIL %s: got y_t=%0d y_b=%0d vel=%0d q=%b want y=%0d vel=%0d q=%b",
                 e.name, bird_y_t, bird_y_b, $signed(velocity), qv(), e.y, e.v, e.q);
      end
      pend--;
    end
  task automatic cyc();
    @(posedge board_clk);
    #1;
  endtask
  task automatic push(input string n, input bit jp);
    int vn, yn;
    exp_t e;
    vn = jp ? -8 : (mv + 1 > 8 ? 8 : mv + 1);
    yn = my + vn;
    if (yn <= 10) begin my = 10; mv = 0; end
    else if (yn >= 470) begin my = 470; mv = 0; mq = QS; end
    else begin my = yn; mv = vn; end
    e.name = n; e.y = my; e.v = mv; e.q = mq;
    sb.push_back(e);
    pend++;
  endtask
  task automatic wait_sb();
    for (int i = 0; i < 100 && pend > 0; i++) @(negedge board_clk);
    if (pend > 0) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got pending=%0d want 0", pend);
      sb.delete();
      pend = 0;
    end
    cyc();
  endtask
  task automatic do_start();
    start = 1; cyc(); start = 0;
    my = 240; mv = 0; mq = QF;
  endtask
  initial begin
    #12;
    check("rst_xl", bird_x_l, 150);
    check("rst_xr", bird_x_r, 170);
    check("rst_yt", bird_y_t, 230);
    check("rst_yb", bird_y_b, 250);
    check("rst_q", qv(), QI);
    check("rst_tick", tick, 0);
    cyc(); Reset = 0; cyc(); cyc();
    check("init_vel", velocity, 0);
    do_start();
    check("start_q", qv(), QF);
    for (int i = 0; i < 3; i++) begin push("gravity", 0); wait_sb(); end
    jump = 1; cyc(); jump = 0;
    push("jump", 1); wait_sb();
    push("after_jump", 0); wait_sb();
    for (int i = 0; i < 40 && my != 10; i++) begin
      jump = 1; cyc(); jump = 0;
      push("ceiling", 1); wait_sb();
    end
    check("ceil_yt", bird_y_t, 0);
    check("ceil_vel", velocity, 0);
    check("ceil_q", qv(), QF);
    for (int i = 0; i < 100 && mq != QS; i++) begin push("fall", 0); wait_sb(); end
    check("ground_yb", bird_y_b, 480);
    check("ground_q", qv(), QS);
    repeat (9) cyc();
    check("stop_frozen_yt", bird_y_t, 460);
    ack = 1; cyc(); ack = 0;
    check("ack_q", qv(), QI);
    check("ack_yt", bird_y_t, 230);
    do_start();
    push("fall2", 0); wait_sb();
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge board_clk); seen = tick; end
      check("race_tick_seen", seen, 1);
    end
    stop = 1; @(negedge board_clk); stop = 0;
    check("race_q", qv(), QS);
    check("race_yt", bird_y_t, 231);
    check("race_vel", velocity, 1);
    cyc();
    start = 1; cyc(); start = 0;
    check("stop_start_ignored", qv(), QS);
    ack = 1; cyc(); ack = 0;
    check("race_ack_yt", bird_y_t, 230);
    do_start();
    push("pre_reset", 0); wait_sb();
    jump = 1; cyc(); jump = 0;
    #3 Reset = 1;
    #1;
    check("mid_rst_xl", bird_x_l, 150);
    check("mid_rst_xr", bird_x_r, 170);
    check("mid_rst_yt", bird_y_t, 230);
    check("mid_rst_yb", bird_y_b, 250);
    check("mid_rst_q", qv(), QI);
    check("mid_rst_vel", velocity, 0);
    #2 Reset = 0;
    cyc();
    do_start();
    push("no_residual_jump", 0); wait_sb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 Parameter: TICK_DIV, default 833333, board_clk cycles per physics tick (about 60 Hz at 50 MHz).
REQ-002 Parameter: BIRD_X, default 160, fixed bird centre X in pixels.
REQ-003 Parameter: Y_INIT, default 240, bird centre Y after reset or ack.
REQ-004 Parameter: HALF, default 10, half-size of the bird box in pixels.
REQ-005 Parameters: GRAVITY default 1; JUMP_VEL default -8; VMAX default 8. All are signed pixels/tick.
REQ-006 Parameters: Y_MIN default 10 (ceiling); Y_MAX default 470 (ground). Legal only if Y_MIN >= HALF and Y_MAX + HALF <= 480.
REQ-007 Port: board_clk, input, 1 bit, system clock (50 MHz).
REQ-008 Port: Reset, input, 1 bit, asynchronous, active-high.
REQ-009 Ports: start, ack, jump, each input, 1 bit, single-cycle debounced pulses in the board_clk domain.
REQ-010 Port: stop, input, 1 bit, level; collision reported by obstacle logic.
REQ-011 Ports: bird_x_l, bird_x_r, bird_y_t, bird_y_b, each output, 10 bits, bird bounding box consumed by the VGA renderer and the obstacle logic.
REQ-012 Port: velocity, output, 10 bits, signed two's-complement current velocity.
REQ-013 Ports: q_initial, q_flight, q_stop, each output, 1 bit, one-hot state.
REQ-014 Port: tick, output, 1 bit, single-cycle physics tick strobe.

Function
REQ-015 States: INITIAL, FLIGHT, STOP. Exactly one q_* output shall be high at all times.
REQ-016 INITIAL: y = Y_INIT and vel = 0. A start pulse moves to FLIGHT on the next edge.
REQ-017 Tick counter: counts 0..TICK_DIV-1 and wraps. tick is high for one cycle at the wrap. It runs in every state.
REQ-018 Jump latch: a jump pulse in FLIGHT sets jump_pending. The latch clears when a tick consumes it. jump in any other state is ignored and clears the latch.
REQ-019 FLIGHT tick update: vel_n = JUMP_VEL if jump_pending, otherwise min(vel + GRAVITY, VMAX). Then y_n = y + vel_n.
REQ-020 Ceiling: if y_n <= Y_MIN, then y = Y_MIN and vel = 0; the state stays FLIGHT.
REQ-021 Ground: if y_n >= Y_MAX, then y = Y_MAX and vel = 0; the state goes to STOP.
REQ-022 Arithmetic: intermediate sum is 11-bit signed, so no wrap is allowed before clamping.
REQ-023 stop = 1 in FLIGHT moves to STOP. If stop and tick occur in the same cycle, stop wins and y/vel are not updated.
REQ-024 STOP: y and vel are frozen. An ack pulse returns to INITIAL, which reloads Y_INIT and vel 0. start is ignored in STOP.
REQ-025 start and ack are ignored outside their own states. If start and ack arrive together in INITIAL, the result is FLIGHT.
REQ-026 Latency: y, vel and the box outputs are registered. They update on the edge after the tick cycle.
REQ-027 Box: bird_x_l = BIRD_X-HALF, bird_x_r = BIRD_X+HALF, bird_y_t = y-HALF, bird_y_b = y+HALF. These are registered and never underflow, given REQ-006.

Reset
REQ-028 Reset shall be asynchronous: state INITIAL, y = Y_INIT, vel = 0, jump_pending = 0, tick counter = 0, tick = 0.
REQ-029 On reset, box outputs shall equal (BIRD_X-HALF, BIRD_X+HALF, Y_INIT-HALF, Y_INIT+HALF).
REQ-030 Reset mid-flight shall abort immediately with no residual jump.

Structure
REQ-031 The state encoding, the screen limits 640/480, and the default physics constants shall live in a shared flappy_pkg package.
REQ-032 The tick prescaler shall be one sub-module, bird_tick_gen (parameter TICK_DIV; inputs board_clk, Reset; output tick).
REQ-033 Total RTL shall be 120-400 lines. There shall be no latches and no derived clocks; only enables on board_clk.

Verification (TICK_DIV = 4)
REQ-034 Gravity: reset, then start, then 3 ticks with no jump -> vel 1, 2, 3; y 241, 243, 246; q_flight = 1.
REQ-035 Jump: from y = 246, vel = 3, pulse jump mid-interval -> at next tick vel = -8, y = 238; a second tick with no jump gives vel = -7, y = 231.
REQ-036 Ceiling and ground: repeated jumps -> y clamps to 10 with vel 0. Free fall from Y_INIT -> y = 470, q_stop = 1, bird_y_b = 480.
REQ-037 Collision race: assert stop in the same cycle as tick -> STOP with y/vel unchanged. ack -> INITIAL with y = 240; start while in STOP is ignored.
REQ-038 Reset mid-flight: assert Reset asynchronously between edges with jump pending -> outputs immediately (150, 170, 230, 250), q_initial = 1; after restart, the first tick gives vel = 1 (no jump).
